spi_flash_read_cache: RTL and testbench
=======================================

Name: spi_flash_read_cache

Overview:
- Read-only, direct-mapped, word-granular cache between an AXI4-Lite-style read channel (AR/R only) and a single-bit SPI NOR flash.
- Hits return from on-chip storage. Misses fetch one 32-bit word with a standard 0x03 READ command, then fill the line.
- The SPI clock is the system clock `aclk` itself, routed directly to the flash, so the block has no SCK output.
- Sits between the CPU/bus fabric and the external flash (flash model: `spiflash`).

Parameters:
- NUM_LINES, 16, number of cache lines; must be a power of 2; one 32-bit word per line.
- ADDR_BITS, 24, flash address width sent in the READ command.

Ports:
- aclk  input  1  system clock; also the SPI clock seen by the flash.
- aresetn  input  1  asynchronous, active-HIGH reset (1 = in reset) despite the name.
- arvalid  input  1  read-address valid.
- arready  output  1  read-address ready.
- araddr  input  32  byte address.
- rvalid  output  1  read-data valid.
- rready  input  1  read-data ready.
- rdata  output  32  read data.
- rresp  output  1  response; always 0 (OKAY).
- csb  output  1  flash chip select, active low.
- io  inout  4  io[0] = MOSI (driven); io[1] = MISO (high-Z, sampled); io[2], io[3] driven 1 (WP#/HOLD# inactive).

Behaviour:
- Reset values: arready=0 while in reset; rvalid=0; rdata=0; rresp=0; csb=1; io[0]=0; all line valid bits cleared; state IDLE.
- Reset mid-transfer: csb rises immediately, the fetch is abandoned, and no line is filled.
- Address decode: araddr[1:0] ignored (word aligned).
  - index = araddr[2 +: log2(NUM_LINES)].
  - tag = araddr[ADDR_BITS-1 : 2+log2(NUM_LINES)].
  - Bits above ADDR_BITS-1 ignored.
- States: IDLE, LOOKUP, SPI_CMD, SPI_ADDR, SPI_DATA, FILL, RESP.
- IDLE
  - arready=1.
  - On an AR handshake (arvalid & arready at a rising edge E0), latch the address and go to LOOKUP.
  - arready=0 in every other state, so only one outstanding read exists.
- LOOKUP (edge E1)
  - Hit (valid & tag match): rdata ← line, rvalid=1, go to RESP. Hit latency: rvalid visible the cycle after the handshake.
  - Miss: go to SPI_CMD.
- SPI timing
  - csb and io[0] change only on falling edges of aclk.
  - io[1] is sampled on rising edges.
  - Bits are MSB first.
- SPI sequence
  - The falling edge after E1 drops csb and drives command bit 7 of 0x03.
  - Rising edges E2–E9: flash samples 8 command bits.
  - E10–E33: 24 address bits = {latched word address, 2'b00}.
  - E34–E65: controller samples 32 data bits on io[1].
  - The falling edge after E65 raises csb; io[0] returns to 0.
- Byte order: flash bytes b0..b3 (addresses A..A+3) assemble little-endian, rdata = {b3,b2,b1,b0}.
- FILL (edge E66): write data, tag and valid=1 into the line, drive rdata, rvalid=1, go to RESP. Miss latency: 66 cycles from handshake to rvalid.
- RESP
  - rvalid and rdata held stable until rready=1 at a rising edge.
  - Then rvalid=0 and return to IDLE; arready=1 the following cycle.
  - rready held high completes the response in the cycle rvalid is first seen.
- Conflict miss: a line with a different tag is overwritten (no other replacement policy).
- csb stays high in IDLE, LOOKUP, FILL and RESP; no flash activity on hits.
- No writes. No error responses.

Test Plan:
- Reset assert 2 cycles then deassert, flash holds 0x11,0x22,0x33,0x44 at 0x000000–3. Read araddr=1 with rready=1 → csb low for 64 cycles, io[0] carries 0x03 then 0x000000, rvalid at E0+66, rdata=0x44332211, rresp=0.
- Repeat the same read → hit: rvalid one cycle after the handshake, csb stays 1, rdata=0x44332211.
- Read 0x40 (same index as 0 with NUM_LINES=16, different tag) → miss refetch and line replaced; a following read of 0x0 misses again.
- Hold rready=0 for 10 cycles after rvalid → rvalid and rdata stable, arready=0 throughout; rready=1 completes the transfer, arready=1 the next cycle.
- Assert reset at E0+30 during a miss → csb=1 and rvalid=0 immediately; after release, a read of 0x0 misses (valid bits cleared).
- Back-to-back reads of 0x4 then 0x8 with arvalid held high → second handshake only after the first R handshake; both return the correct little-endian words.

Source files
------------

// File: rtl/spi_flash_read_cache.sv
// Read-only direct-mapped word cache in front of a single-bit SPI NOR flash.
// Misses issue a 0x03 READ for one word; aclk doubles as the flash SCK.
module spi_flash_read_cache #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_BITS = 24
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        arvalid,
  output logic        arready,
  input  logic [31:0] araddr,
  output logic        rvalid,
  input  logic        rready,
  output logic [31:0] rdata,
  output logic        rresp,
  output logic        csb,
  inout  wire  [3:0]  io
);

  localparam int IDX_BITS   = $clog2(NUM_LINES);
  localparam int WADDR_BITS = ADDR_BITS - 2;
  localparam int TAG_BITS   = WADDR_BITS - IDX_BITS;
  localparam int TX_BITS    = 8 + ADDR_BITS;

  localparam logic [7:0] READ_CMD = 8'h03;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOOKUP   = 3'd1;
  localparam logic [2:0] ST_SPI_CMD  = 3'd2;
  localparam logic [2:0] ST_SPI_ADDR = 3'd3;
  localparam logic [2:0] ST_SPI_DATA = 3'd4;
  localparam logic [2:0] ST_FILL     = 3'd5;
  localparam logic [2:0] ST_RESP     = 3'd6;

  logic [2:0]            r_state;
  logic [WADDR_BITS-1:0] r_waddr;
  logic [5:0]            r_cnt;
  logic [TX_BITS-1:0]    r_tx;
  logic [31:0]           r_shift;
  logic [31:0]           r_rdata;
  logic                  r_rvalid;
  logic                  r_csb;
  logic                  r_mosi;
  logic [NUM_LINES-1:0]  r_line_valid;
  logic [31:0]           r_line_data [NUM_LINES];
  logic [TAG_BITS-1:0]   r_line_tag  [NUM_LINES];

  wire [IDX_BITS-1:0] w_idx = r_waddr[IDX_BITS-1:0];
  wire [TAG_BITS-1:0] w_tag = r_waddr[WADDR_BITS-1:IDX_BITS];
  wire                w_hit = r_line_valid[w_idx] && (r_line_tag[w_idx] == w_tag);
  wire                w_spi_active = (r_state == ST_SPI_CMD) || (r_state == ST_SPI_ADDR) ||
                                     (r_state == ST_SPI_DATA);
  wire                w_spi_tx     = (r_state == ST_SPI_CMD) || (r_state == ST_SPI_ADDR);
  // Flash bytes arrive MSB-first in address order; the word is little-endian.
  wire [31:0] w_fetched = {r_shift[7:0], r_shift[15:8], r_shift[23:16], r_shift[31:24]};
  wire [33-ADDR_BITS:0] w_unused_addr = {araddr[31:ADDR_BITS], araddr[1:0]};

  assign arready = (r_state == ST_IDLE) && !aresetn;
  assign rvalid  = r_rvalid;
  assign rdata   = r_rdata;
  assign rresp   = 1'b0;
  assign csb     = r_csb;
  assign io[0]   = r_mosi;
  assign io[1]   = 1'bz;
  assign io[2]   = 1'b1;
  assign io[3]   = 1'b1;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_state      <= ST_IDLE;
      r_waddr      <= '0;
      r_cnt        <= '0;
      r_tx         <= '0;
      r_shift      <= '0;
      r_rdata      <= '0;
      r_rvalid     <= 1'b0;
      r_line_valid <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arvalid) begin
            r_waddr <= araddr[ADDR_BITS-1:2];
            r_state <= ST_LOOKUP;
          end
        end
        ST_LOOKUP: begin
          if (w_hit) begin
            r_rdata  <= r_line_data[w_idx];
            r_rvalid <= 1'b1;
            r_state  <= ST_RESP;
          end else begin
            r_cnt   <= '0;
            r_tx    <= {READ_CMD, r_waddr, 2'b00};
            r_state <= ST_SPI_CMD;
          end
        end
        ST_SPI_CMD: begin
          r_tx  <= {r_tx[TX_BITS-2:0], 1'b0};
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd7) r_state <= ST_SPI_ADDR;
        end
        ST_SPI_ADDR: begin
          r_tx <= {r_tx[TX_BITS-2:0], 1'b0};
          if (r_cnt == 6'(TX_BITS - 1)) begin
            r_cnt   <= '0;
            r_state <= ST_SPI_DATA;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_SPI_DATA: begin
          r_shift <= {r_shift[30:0], io[1]};
          if (r_cnt == 6'd31) begin
            r_cnt   <= '0;
            r_state <= ST_FILL;
          end else begin
            r_cnt <= r_cnt + 6'd1;
          end
        end
        ST_FILL: begin
          r_line_valid[w_idx] <= 1'b1;
          r_rdata             <= w_fetched;
          r_rvalid            <= 1'b1;
          r_state             <= ST_RESP;
        end
        ST_RESP: begin
          if (rready) begin
            r_rvalid <= 1'b0;
            r_state  <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // NOTE: line data and tags are not reset; the valid bits alone make stale
  // contents unreachable, which keeps the storage a plain RAM.
  always_ff @(posedge aclk) begin
    if (!aresetn && (r_state == ST_FILL)) begin
      r_line_data[w_idx] <= w_fetched;
      r_line_tag[w_idx]  <= w_tag;
    end
  end

  // Flash samples on rising edges, so chip select and MOSI launch on falling edges.
  always_ff @(negedge aclk or posedge aresetn) begin
    if (aresetn) begin
      r_csb  <= 1'b1;
      r_mosi <= 1'b0;
    end else begin
      r_csb  <= !w_spi_active;
      r_mosi <= w_spi_tx ? r_tx[TX_BITS-1] : 1'b0;
    end
  end

endmodule

// File: tb/tb_spi_flash_read_cache.sv
// Directed bench for spi_flash_read_cache with a small behavioural 0x03-READ flash.
module tb_spi_flash_read_cache;

  logic        aclk    = 1'b0;
  logic        aresetn = 1'b0;
  logic        arvalid = 1'b0;
  logic [31:0] araddr  = '0;
  logic        rready  = 1'b0;
  wire         arready;
  wire         rvalid;
  wire  [31:0] rdata;
  wire         rresp;
  wire         csb;
  wire  [3:0]  io;

  int checks   = 0;
  int failures = 0;

  always #5 aclk = ~aclk;

  spi_flash_read_cache #(.NUM_LINES(16), .ADDR_BITS(24)) dut (
    .aclk    (aclk),
    .aresetn (aresetn),
    .arvalid (arvalid),
    .arready (arready),
    .araddr  (araddr),
    .rvalid  (rvalid),
    .rready  (rready),
    .rdata   (rdata),
    .rresp   (rresp),
    .csb     (csb),
    .io      (io)
  );

  // Flash model: 32 bits of command+address in, then data bits out on falling edges.
  logic [7:0]  fl_mem [256];
  int          fl_cnt = 0;
  logic [31:0] fl_cmd_addr = '0;
  logic        fl_out = 1'b0;
  int          fl_low_cycles = 0;
  int          fl_txns = 0;

  function automatic logic flash_bit(input logic [7:0] a, input int d);
    logic [7:0] b;
    b = fl_mem[a + 8'(d / 8)];
    return b[3'(7 - (d % 8))];
  endfunction

  always @(posedge aclk or posedge csb) begin
    if (csb) begin
      fl_cnt <= 0;
    end else begin
      if (fl_cnt < 32) fl_cmd_addr <= {fl_cmd_addr[30:0], io[0]};
      fl_cnt <= fl_cnt + 1;
    end
  end

  always @(negedge aclk) begin
    if (!csb && fl_cnt >= 32) fl_out <= flash_bit(fl_cmd_addr[7:0], fl_cnt - 32);
  end

  always @(posedge aclk) begin
    if (!csb) fl_low_cycles <= fl_low_cycles + 1;
  end

  always @(negedge csb) fl_txns <= fl_txns + 1;

  assign io[1] = csb ? 1'bz : fl_out;

  task automatic start_ar(input logic [31:0] a);
    int n;
    @(negedge aclk);
    arvalid = 1'b1;
    araddr  = a;
    n = 0;
    while (!arready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL ar_handshake addr=%h arready=%b required 1", a, arready);
    end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
  endtask

  task automatic wait_rvalid(output int lat);
    lat = 0;
    for (int i = 0; i < 200; i++) begin
      @(posedge aclk);
      lat++;
      #1;
      if (rvalid) break;
    end
    if (!rvalid) lat = -1;
  endtask

  task automatic do_read(input logic [31:0] a, output int lat, output logic [31:0] d,
                         output logic resp);
    start_ar(a);
    wait_rvalid(lat);
    d    = rdata;
    resp = rresp;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    repeat (2) @(posedge aclk);
    #1;
    checks++;
    if ({arready, rvalid, rresp, csb, io[0]} !== 5'b00010) begin
      failures++;
      $display("FAIL reset_ctrl arready/rvalid/rresp/csb/mosi=%b required 00010",
               {arready, rvalid, rresp, csb, io[0]});
    end
    checks++;
    if (rdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_rdata got %h required 00000000", rdata);
    end
    @(negedge aclk);
    aresetn = 1'b0;
    #1;
    checks++;
    if (arready !== 1'b1) begin
      failures++;
      $display("FAIL reset_release_arready got %b required 1", arready);
    end
  endtask

  task automatic test_miss();
    int lat, t0, l0;
    logic [31:0] d;
    logic resp;
    rready = 1'b1;
    t0 = fl_txns;
    l0 = fl_low_cycles;
    do_read(32'h1, lat, d, resp);
    checks++;
    if (lat !== 66) begin
      failures++;
      $display("FAIL miss_latency got %0d required 66", lat);
    end
    checks++;
    if (d !== 32'h44332211) begin
      failures++;
      $display("FAIL miss_rdata got %h required 44332211", d);
    end
    checks++;
    if (resp !== 1'b0) begin
      failures++;
      $display("FAIL miss_rresp got %b required 0", resp);
    end
    checks++;
    if (fl_low_cycles - l0 !== 64) begin
      failures++;
      $display("FAIL miss_csb_low got %0d required 64", fl_low_cycles - l0);
    end
    checks++;
    if (fl_cmd_addr !== 32'h03000000) begin
      failures++;
      $display("FAIL miss_cmd_addr got %h required 03000000", fl_cmd_addr);
    end
    checks++;
    if (fl_txns - t0 !== 1) begin
      failures++;
      $display("FAIL miss_txns got %0d required 1", fl_txns - t0);
    end
    checks++;
    if ({rvalid, arready, csb, io[0]} !== 4'b0110) begin
      failures++;
      $display("FAIL miss_done rvalid/arready/csb/mosi=%b required 0110",
               {rvalid, arready, csb, io[0]});
    end
  endtask

  task automatic test_hit();
    int lat, t0;
    logic [31:0] d;
    logic resp;
    t0 = fl_txns;
    do_read(32'h1, lat, d, resp);
    checks++;
    if (lat !== 1 || d !== 32'h44332211) begin
      failures++;
      $display("FAIL hit_repeat lat=%0d data=%h required lat=1 data=44332211", lat, d);
    end
    // Bits above the flash address width must not take part in the tag.
    do_read(32'hFF00_0003, lat, d, resp);
    checks++;
    if (lat !== 1 || d !== 32'h44332211) begin
      failures++;
      $display("FAIL hit_high_bits lat=%0d data=%h required lat=1 data=44332211", lat, d);
    end
    checks++;
    if (fl_txns - t0 !== 0) begin
      failures++;
      $display("FAIL hit_no_flash txns=%0d required 0", fl_txns - t0);
    end
  endtask

  task automatic test_conflict();
    int lat;
    logic [31:0] d;
    logic resp;
    do_read(32'h40, lat, d, resp);
    checks++;
    if (lat !== 66 || d !== 32'hD4C3B2A1) begin
      failures++;
      $display("FAIL conflict_fetch lat=%0d data=%h required lat=66 data=d4c3b2a1", lat, d);
    end
    checks++;
    if (fl_cmd_addr !== 32'h03000040) begin
      failures++;
      $display("FAIL conflict_cmd_addr got %h required 03000040", fl_cmd_addr);
    end
    do_read(32'h0, lat, d, resp);
    checks++;
    if (lat !== 66 || d !== 32'h44332211) begin
      failures++;
      $display("FAIL conflict_refetch lat=%0d data=%h required lat=66 data=44332211", lat, d);
    end
  endtask

  task automatic test_rready_hold();
    int lat;
    logic [31:0] d0;
    logic stable;
    rready = 1'b0;
    start_ar(32'h0);
    wait_rvalid(lat);
    d0 = rdata;
    checks++;
    if (lat !== 1 || d0 !== 32'h44332211) begin
      failures++;
      $display("FAIL hold_hit lat=%0d data=%h required lat=1 data=44332211", lat, d0);
    end
    stable = 1'b1;
    repeat (10) begin
      @(negedge aclk);
      if (rvalid !== 1'b1 || rdata !== d0 || arready !== 1'b0) stable = 1'b0;
    end
    checks++;
    if (stable !== 1'b1) begin
      failures++;
      $display("FAIL hold_stable rvalid=%b rdata=%h arready=%b required 1 %h 0",
               rvalid, rdata, arready, d0);
    end
    rready = 1'b1;
    @(posedge aclk);
    #1;
    checks++;
    if ({rvalid, arready} !== 2'b01) begin
      failures++;
      $display("FAIL hold_release rvalid/arready=%b required 01", {rvalid, arready});
    end
  endtask

  task automatic test_reset_mid();
    int lat;
    logic [31:0] d;
    logic resp;
    rready = 1'b1;
    start_ar(32'h8);
    repeat (30) @(posedge aclk);
    #1;
    aresetn = 1'b1;
    #1;
    checks++;
    if ({csb, rvalid, arready} !== 3'b100) begin
      failures++;
      $display("FAIL midreset csb/rvalid/arready=%b required 100", {csb, rvalid, arready});
    end
    repeat (2) @(posedge aclk);
    @(negedge aclk);
    aresetn = 1'b0;
    do_read(32'h0, lat, d, resp);
    checks++;
    if (lat !== 66 || d !== 32'h44332211) begin
      failures++;
      $display("FAIL midreset_refetch lat=%0d data=%h required lat=66 data=44332211", lat, d);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2, n;
    logic [31:0] d1, d2;
    logic early;
    rready  = 1'b1;
    @(negedge aclk);
    arvalid = 1'b1;
    araddr  = 32'h4;
    n = 0;
    while (!arready && n < 200) begin
      @(negedge aclk);
      n++;
    end
    @(posedge aclk);
    @(negedge aclk);
    araddr = 32'h8;
    early = 1'b0;
    lat1  = -1;
    for (int i = 1; i <= 200; i++) begin
      @(posedge aclk);
      #1;
      if (arready) early = 1'b1;
      if (rvalid) begin
        lat1 = i;
        break;
      end
    end
    d1 = rdata;
    @(posedge aclk);
    #1;
    checks++;
    if (early !== 1'b0 || arready !== 1'b1 || rvalid !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gap early=%b arready=%b rvalid=%b required 0 1 0",
               early, arready, rvalid);
    end
    @(posedge aclk);
    @(negedge aclk);
    arvalid = 1'b0;
    wait_rvalid(lat2);
    d2 = rdata;
    @(posedge aclk);
    #1;
    checks++;
    if (lat1 !== 66 || d1 !== 32'h88776655) begin
      failures++;
      $display("FAIL b2b_first lat=%0d data=%h required lat=66 data=88776655", lat1, d1);
    end
    checks++;
    if (lat2 !== 66 || d2 !== 32'hCCBBAA99) begin
      failures++;
      $display("FAIL b2b_second lat=%0d data=%h required lat=66 data=ccbbaa99", lat2, d2);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) fl_mem[i] = 8'h00;
    fl_mem[0]  = 8'h11; fl_mem[1]  = 8'h22; fl_mem[2]  = 8'h33; fl_mem[3]  = 8'h44;
    fl_mem[4]  = 8'h55; fl_mem[5]  = 8'h66; fl_mem[6]  = 8'h77; fl_mem[7]  = 8'h88;
    fl_mem[8]  = 8'h99; fl_mem[9]  = 8'hAA; fl_mem[10] = 8'hBB; fl_mem[11] = 8'hCC;
    fl_mem[64] = 8'hA1; fl_mem[65] = 8'hB2; fl_mem[66] = 8'hC3; fl_mem[67] = 8'hD4;
    test_reset();
    test_miss();
    test_hit();
    test_conflict();
    test_rready_hold();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
